// File: rtl/rca_writeback_sequencer_pkg.sv
// Shared types and default sizing for the RCA writeback return path.
// Optional feature macro: RCA_WB_DUP_SUPPRESS_EN (see rca_writeback_sequencer.sv).
package rca_writeback_sequencer_pkg;

   localparam int RCA_XLEN            = 32;
   localparam int RCA_NUM_WRITE_PORTS = 2;
   localparam int RCA_MAX_IDS         = 4;
   localparam int RCA_ID_W            = $clog2(RCA_MAX_IDS);

   typedef logic [RCA_ID_W-1:0] id_t;

   typedef struct packed {
      id_t                 id;
      logic [4:0]          rd_addr;
      logic [RCA_XLEN-1:0] data;
      logic                we;
      logic                last;
   } rca_wb_packet_t;

   typedef enum logic {
      RCA_WB_IDLE  = 1'b0,
      RCA_WB_DRAIN = 1'b1
   } rca_wb_state_t;

endpackage

// File: rtl/rca_writeback_sequencer_port_select.sv
// Lowest-set-bit priority encoder over the pending write ports.
// one_left flags that exactly one pending bit remains.
module rca_writeback_sequencer_port_select
   import rca_writeback_sequencer_pkg::*;
#(
   parameter int N  = RCA_NUM_WRITE_PORTS,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  pending_i,
   output logic [PW-1:0] index_o,
   output logic          found_o,
   output logic          one_left_o
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      index_o = '0;
      found_o = 1'b0;
      for (int p = N - 1; p >= 0; p--) begin
         if (pending_i[p]) begin
            index_o = PW'(p);
            found_o = 1'b1;
         end
      end
      one_left_o = (pending_i != '0) && ((pending_i & (pending_i - 1'b1)) == '0);
   end

endmodule

// File: rtl/rca_writeback_sequencer.sv
// Serializes the result words of one completed RCA operation onto the single
// writeback port, tagged with the instruction id.
// Optional feature macro: RCA_WB_DUP_SUPPRESS_EN -- when defined, a pending
// port whose rd matches a higher-index pending port is dropped at capture.
//
// state        | meaning
// RCA_WB_IDLE  | ready to accept a completed operation
// RCA_WB_DRAIN | emitting beats of the held operation
module rca_writeback_sequencer
   import rca_writeback_sequencer_pkg::*;
#(
   parameter int XLEN            = RCA_XLEN,
   parameter int NUM_WRITE_PORTS = RCA_NUM_WRITE_PORTS,
   parameter int ID_W            = RCA_ID_W
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         rca_done_valid,
   output logic                         rca_done_ready,
   input  logic [ID_W-1:0]              rca_id,
   input  logic [NUM_WRITE_PORTS*XLEN-1:0] rca_results,
   input  logic [NUM_WRITE_PORTS-1:0]   rca_result_mask,
   input  logic [5*NUM_WRITE_PORTS-1:0] rca_dest_reg_addrs,
   output logic                         wb_valid,
   input  logic                         wb_ack,
   output logic [ID_W-1:0]              wb_id,
   output logic [4:0]                   wb_rd_addr,
   output logic [XLEN-1:0]              wb_data,
   output logic                         wb_we,
   output logic                         wb_last,
   output logic                         busy
);

   localparam int N  = NUM_WRITE_PORTS;
   localparam int PW = (N > 1) ? $clog2(N) : 1;

   rca_wb_state_t        state_q, state_d;
   logic [ID_W-1:0]      id_q;
   logic [N*XLEN-1:0]    results_q;
   logic [5*N-1:0]       dest_q;
   logic [N-1:0]         pending_q, pending_d;
   logic [N-1:0]         base_pending, cap_pending;
   logic                 accept, beat_done, beat_last;
   logic [PW-1:0]        sel_idx;
   logic                 sel_found, sel_one_left;
   logic [4:0]           sel_rd;
   logic [XLEN-1:0]      sel_data;

   rca_writeback_sequencer_port_select #(.N(N), .PW(PW)) u_port_select (
      .pending_i  (pending_q),
      .index_o    (sel_idx),
      .found_o    (sel_found),
      .one_left_o (sel_one_left)
   );

   assign accept    = rca_done_valid && (state_q == RCA_WB_IDLE);
   assign beat_last = sel_found ? sel_one_left : 1'b1;
   assign beat_done = (state_q == RCA_WB_DRAIN) && wb_ack;

   // Ports that will actually write: masked in, not targeting x0, and
   // optionally not shadowed by a later port writing the same rd.
   always_comb begin
      base_pending = '0;
      for (int p = 0; p < N; p++) begin
         base_pending[p] = rca_result_mask[p] && (rca_dest_reg_addrs[p*5 +: 5] != 5'd0);
      end
      cap_pending = base_pending;
`ifdef RCA_WB_DUP_SUPPRESS_EN
      for (int p = 0; p < N; p++) begin
         for (int q = p + 1; q < N; q++) begin
            if (base_pending[p] && base_pending[q] &&
                (rca_dest_reg_addrs[q*5 +: 5] == rca_dest_reg_addrs[p*5 +: 5])) begin
               cap_pending[p] = 1'b0;
            end
         end
      end
`endif
   end

   // Mux the selected port's rd/data and retire its pending bit on ack.
   always_comb begin
      sel_rd    = '0;
      sel_data  = '0;
      pending_d = pending_q;
      for (int p = 0; p < N; p++) begin
         if (sel_found && (sel_idx == PW'(p))) begin
            sel_rd       = dest_q[p*5 +: 5];
            sel_data     = results_q[p*XLEN +: XLEN];
            pending_d[p] = 1'b0;
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= RCA_WB_IDLE;
      else        state_q <= state_d;
   end

   // Next-state: accept from IDLE, leave DRAIN on the acked last beat.
   always_comb begin
      state_d = state_q;
      case (state_q)
         RCA_WB_IDLE:  if (accept) state_d = RCA_WB_DRAIN;
         RCA_WB_DRAIN: if (wb_ack && beat_last) state_d = RCA_WB_IDLE;
         default:      state_d = RCA_WB_IDLE;
      endcase
   end

   // Capture registers load only on accept; pending bits drain on ack.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_q      <= '0;
         results_q <= '0;
         dest_q    <= '0;
         pending_q <= '0;
      end else if (accept) begin
         id_q      <= rca_id;
         results_q <= rca_results;
         dest_q    <= rca_dest_reg_addrs;
         pending_q <= cap_pending;
      end else if (beat_done) begin
         pending_q <= pending_d;
      end
   end

   // Outputs decoded from state; an empty pending set gives a retire-only beat.
   always_comb begin
      rca_done_ready = 1'b0;
      busy           = 1'b0;
      wb_valid       = 1'b0;
      wb_we          = 1'b0;
      wb_last        = 1'b0;
      wb_id          = '0;
      wb_rd_addr     = '0;
      wb_data        = '0;
      case (state_q)
         RCA_WB_IDLE: rca_done_ready = 1'b1;
         RCA_WB_DRAIN: begin
            busy     = 1'b1;
            wb_valid = 1'b1;
            wb_id    = id_q;
            wb_last  = beat_last;
            if (sel_found) begin
               wb_we      = 1'b1;
               wb_rd_addr = sel_rd;
               wb_data    = sel_data;
            end
         end
         default: rca_done_ready = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_rca_writeback_sequencer.sv
// Directed and randomized bench for rca_writeback_sequencer.
module tb_rca_writeback_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rca_done_valid;
   logic        rca_done_ready;
   logic [1:0]  rca_id;
   logic [63:0] rca_results;
   logic [1:0]  rca_result_mask;
   logic [9:0]  rca_dest_reg_addrs;
   logic        wb_valid;
   logic        wb_ack;
   logic [1:0]  wb_id;
   logic [4:0]  wb_rd_addr;
   logic [31:0] wb_data;
   logic        wb_we;
   logic        wb_last;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [1:0]  id;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        we;
      logic        last;
   } beat_t;

   beat_t exp_q[$];

   rca_writeback_sequencer dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .rca_done_valid     (rca_done_valid),
      .rca_done_ready     (rca_done_ready),
      .rca_id             (rca_id),
      .rca_results        (rca_results),
      .rca_result_mask    (rca_result_mask),
      .rca_dest_reg_addrs (rca_dest_reg_addrs),
      .wb_valid           (wb_valid),
      .wb_ack             (wb_ack),
      .wb_id              (wb_id),
      .wb_rd_addr         (wb_rd_addr),
      .wb_data            (wb_data),
      .wb_we              (wb_we),
      .wb_last            (wb_last),
      .busy               (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Reference: writes in ascending port order, x0 dropped, optional last-writer-wins.
   function automatic void build_expected(input logic [1:0] id, input logic [63:0] res,
                                          input logic [1:0] mask, input logic [9:0] dest);
      beat_t b;
      logic  keep;
      exp_q.delete();
      for (int p = 0; p < 2; p++) begin
         keep = mask[p] && (dest[p*5 +: 5] != 5'd0);
`ifdef RCA_WB_DUP_SUPPRESS_EN
         for (int q = p + 1; q < 2; q++)
            if (mask[q] && dest[q*5 +: 5] != 5'd0 && dest[q*5 +: 5] == dest[p*5 +: 5]) keep = 1'b0;
`endif
         if (keep) begin
            b.id = id; b.rd = dest[p*5 +: 5]; b.data = res[p*32 +: 32]; b.we = 1'b1; b.last = 1'b0;
            exp_q.push_back(b);
         end
      end
      if (exp_q.size() == 0) begin
         b.id = id; b.rd = 5'd0; b.data = 32'd0; b.we = 1'b0; b.last = 1'b1;
         exp_q.push_back(b);
      end else begin
         exp_q[exp_q.size()-1].last = 1'b1;
      end
   endfunction

   task automatic check_beat(input beat_t b);
      chk("wb_valid", 64'(wb_valid), 64'd1);
      chk("busy", 64'(busy), 64'd1);
      chk("ready_drain", 64'(rca_done_ready), 64'd0);
      chk("wb_id", 64'(wb_id), 64'(b.id));
      chk("wb_rd_addr", 64'(wb_rd_addr), 64'(b.rd));
      chk("wb_data", 64'(wb_data), 64'(b.data));
      chk("wb_we", 64'(wb_we), 64'(b.we));
      chk("wb_last", 64'(wb_last), 64'(b.last));
   endtask

   task automatic scramble_inputs();
      rca_id             = 2'($urandom);
      rca_results        = {$urandom, $urandom};
      rca_result_mask    = 2'($urandom);
      rca_dest_reg_addrs = 10'($urandom);
   endtask

   task automatic present_op(input logic [1:0] id, input logic [63:0] res,
                             input logic [1:0] mask, input logic [9:0] dest);
      build_expected(id, res, mask, dest);
      @(negedge clk);
      chk("ready_idle", 64'(rca_done_ready), 64'd1);
      rca_done_valid = 1'b1; rca_id = id; rca_results = res;
      rca_result_mask = mask; rca_dest_reg_addrs = dest;
      @(negedge clk);
      rca_done_valid = 1'b0;
      scramble_inputs();
   endtask

   // stalls < 0 picks a random 0..2 stall per beat.
   task automatic run_op(input logic [1:0] id, input logic [63:0] res,
                         input logic [1:0] mask, input logic [9:0] dest, input int stalls);
      int ns;
      present_op(id, res, mask, dest);
      foreach (exp_q[i]) begin
         ns = (stalls >= 0) ? stalls : int'($urandom_range(0, 2));
         for (int s = 0; s < ns; s++) begin
            wb_ack = 1'b0;
            check_beat(exp_q[i]);
            rca_done_valid = 1'b1;
            scramble_inputs();
            @(negedge clk);
         end
         rca_done_valid = 1'b0;
         wb_ack = 1'b1;
         check_beat(exp_q[i]);
         @(negedge clk);
      end
      wb_ack = 1'b0;
      chk("exit_valid", 64'(wb_valid), 64'd0);
      chk("exit_ready", 64'(rca_done_ready), 64'd1);
      chk("exit_busy", 64'(busy), 64'd0);
   endtask

   initial begin
      logic [1:0]  r_mask;
      logic [9:0]  r_dest;
      logic [4:0]  d0, d1;
      rst_n = 1'b0; rca_done_valid = 1'b0; wb_ack = 1'b0;
      rca_id = '0; rca_results = '0; rca_result_mask = '0; rca_dest_reg_addrs = '0;
      #1;
      chk("rst_ready", 64'(rca_done_ready), 64'd1);
      chk("rst_valid", 64'(wb_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_we_last", {62'd0, wb_we, wb_last}, 64'd0);
      chk("rst_fields", {25'd0, wb_id, wb_rd_addr, wb_data}, 64'd0);
      @(negedge clk); rst_n = 1'b1;

      // Stray ack while idle must not start anything.
      @(negedge clk); wb_ack = 1'b1;
      @(negedge clk); wb_ack = 1'b0;
      chk("idle_ack_valid", 64'(wb_valid), 64'd0);
      chk("idle_ack_ready", 64'(rca_done_ready), 64'd1);

      // Test 1: two beats, ack held.
      run_op(2'd2, {32'hBBBB0000, 32'hAAAA0000}, 2'b11, {5'd7, 5'd5}, 0);
      // Test 2: backpressure, 3 stall cycles per beat.
      run_op(2'd2, {32'hBBBB0000, 32'hAAAA0000}, 2'b11, {5'd7, 5'd5}, 3);
      // Test 3: all dests x0 -> retire-only beat.
      run_op(2'd1, {32'h1234_5678, 32'h9ABC_DEF0}, 2'b11, {5'd0, 5'd0}, 0);
      // Test 4: only port 1.
      run_op(2'd3, {32'hCAFE_F00D, 32'hDEAD_BEEF}, 2'b10, {5'd12, 5'd4}, 1);
      // Test 5: duplicate rd.
      run_op(2'd0, {32'h2222_2222, 32'h1111_1111}, 2'b11, {5'd9, 5'd9}, 0);

      // Test 6: reset during the second beat.
      present_op(2'd2, {32'hBBBB0000, 32'hAAAA0000}, 2'b11, {5'd7, 5'd5});
      wb_ack = 1'b1;
      check_beat(exp_q[0]);
      @(negedge clk);
      wb_ack = 1'b0;
      check_beat(exp_q[1]);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", 64'(wb_valid), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_ready", 64'(rca_done_ready), 64'd1);
      chk("midrst_fields", {23'd0, wb_we, wb_last, wb_id, wb_rd_addr, wb_data}, 64'd0);
      @(negedge clk); rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         wb_ack = 1'b1;
         @(negedge clk);
         chk("postrst_valid", 64'(wb_valid), 64'd0);
      end
      wb_ack = 1'b0;
      run_op(2'd1, {32'h0F0F_0F0F, 32'hF0F0_F0F0}, 2'b01, {5'd3, 5'd31}, 0);

      // Randomized operations, biased toward x0 and duplicate rds.
      for (int t = 0; t < 40; t++) begin
         r_mask = 2'($urandom);
         d0 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
         d1 = ($urandom_range(0, 2) == 0) ? d0 : 5'($urandom_range(0, 3));
         r_dest = {d1, d0};
         run_op(2'($urandom), {$urandom, $urandom}, r_mask, r_dest, -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rca_writeback_sequencer.md
Name: rca_writeback_sequencer

Overview:
- Return path of the reconfigurable custom accelerator (RCA). Operands travel into the RCA as rs1..rs5; this block handles the results coming back.
- Accepts one completed RCA operation carrying up to NUM_WRITE_PORTS result words.
- Serializes those words onto the single RCA writeback port, tagged with the instruction id.
- Destination registers come from the dest half of the RCA config outputs (rca_dest_reg_addrs).

Parameters:
- XLEN, 32, result word width.
- NUM_WRITE_PORTS, 2, RCA result ports; default is taken from rca_config.
- ID_W, 2, instruction id width; equals $clog2(MAX_IDS).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- rca_done_valid  in  1  RCA presents a completed operation.
- rca_done_ready  out  1  sequencer can accept an operation.
- rca_id  in  ID_W  id of the completing instruction.
- rca_results  in  NUM_WRITE_PORTS*XLEN  result words; port p occupies bits [p*XLEN +: XLEN].
- rca_result_mask  in  NUM_WRITE_PORTS  bit p set = port p produced a result.
- rca_dest_reg_addrs  in  5*NUM_WRITE_PORTS  rd per write port; port p occupies bits [p*5 +: 5].
- wb_valid  out  1  writeback beat present.
- wb_ack  in  1  writeback consumer takes the beat.
- wb_id  out  ID_W  id of the beat.
- wb_rd_addr  out  5  destination register.
- wb_data  out  XLEN  result word.
- wb_we  out  1  register write enable; 0 = retire-only beat.
- wb_last  out  1  final beat of this operation.
- busy  out  1  an operation is held.

Behaviour:
- Interface: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, rca_done_ready=1, wb_valid=0, wb_we=0, wb_last=0, busy=0, wb_id/wb_rd_addr/wb_data=0, all captured registers zeroed.
- States: IDLE, DRAIN.
- rca_done_ready = (state==IDLE). There is no same-cycle bypass from DRAIN.
- Capture: on rca_done_valid && rca_done_ready, latch rca_id, rca_results, rca_dest_reg_addrs, and pending = rca_result_mask & ~(dest==0) per port. Writes to x0 are dropped. State -> DRAIN.
- Latency: capture in cycle N; first wb_valid in cycle N+1.
- Beat selection in DRAIN: the lowest-index set bit of pending drives wb_rd_addr and wb_data, with wb_we=1.
  - wb_last=1 when exactly one bit of pending remains.
- Empty operation: if pending==0 at capture, DRAIN emits exactly one beat with wb_we=0, wb_rd_addr=0, wb_data=0, wb_last=1. This retires the id.
- Handshake:
  - wb_valid stays high in DRAIN.
  - All wb_* outputs are stable while wb_valid && !wb_ack.
  - On wb_ack, clear the selected pending bit; the next beat appears in the following cycle (one beat per cycle maximum).
  - wb_ack while wb_valid=0 is ignored.
- Exit: an acked beat with wb_last=1 moves the state to IDLE; rca_done_ready=1 in the next cycle.
- busy = (state==DRAIN).
- Reset mid-DRAIN: the operation is discarded, no further beats are emitted, and all outputs return to reset values asynchronously.
- The capture registers are written only on an accept handshake; input changes during DRAIN are ignored.

Optional Feature:
- Macro: RCA_WB_DUP_SUPPRESS_EN.
- Defined: at capture, a pending port whose rd equals the rd of any higher-index pending port is cleared. Last writer wins and the beat count drops accordingly.
- Not defined: duplicate rds are all written in ascending port order. The architectural result is the same, but there are more beats.

Decomposition:
- taiga_types additions:
  - typedef rca_wb_packet_t {id_t id; logic [4:0] rd_addr; logic [XLEN-1:0] data; logic we; logic last;}.
  - enum rca_wb_state_t {RCA_WB_IDLE, RCA_WB_DRAIN}.
- rca_config: NUM_WRITE_PORTS (existing constant).
- Sub-module rca_wb_port_select: combinational lowest-set-bit priority encoder. Outputs index, found, and one_left (popcount==1).

Test Plan:
1. mask=2'b11, dest={p1:7, p0:5}, results={p1:0xBBBB0000, p0:0xAAAA0000}, id=2, wb_ack held 1 -> cycle N+1: rd=5 data=0xAAAA0000 last=0; N+2: rd=7 data=0xBBBB0000 last=1; ready=1 at N+3.
2. Backpressure: as test 1 with wb_ack=0 for 3 cycles -> first beat (rd=5) held stable 3 cycles; rca_done_valid asserted meanwhile is not accepted (ready=0).
3. dest={p1:0, p0:0}, mask=2'b11, id=1 -> single beat we=0 rd=0 data=0 id=1 last=1.
4. mask=2'b10, dest p1=12 -> single beat rd=12 data=p1 word last=1; port 0 is never emitted.
5. dest={p1:9, p0:9}, mask=2'b11 -> with RCA_WB_DUP_SUPPRESS_EN: one beat rd=9 data=p1 word last=1; without it: two beats, p0 then p1.
6. rst_n low during second beat of test 1 -> wb_valid=0 immediately, busy=0, ready=1; after release, no stale beat appears and a new op is accepted normally.
